fetch_queue: RTL and testbench

Instruction prefetch buffer between the instruction memory and the IF/ID pipeline register. It owns the fetch PC and reads one word per cycle from a combinational instruction memory port. Fetched words are held in a small FIFO together with their PC+4, and the head entry is presented to IF/ID. Stalls from the hazard unit no longer stop fetch, and a taken branch flushes every buffered entry.

---
 rtl/fetch_queue.sv | 154 +++++++++++++++
 tb/tb_fetch_queue.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch FIFO between instruction memory and IF/ID
//
// Owns the fetch PC, reads one word per cycle from a combinational
// instruction memory port and buffers {instr, pc+4} pairs in a small FIFO.
// The head entry is presented to the IF/ID register; a taken branch (flush)
// discards every buffered entry and redirects fetch.
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to present memData directly
// at the outputs while the queue is empty (zero-cycle fetch latency).
//
// Parameters:
//   DEPTH     queue entries (power of two, >= 2)
//   PTR_W     log2(DEPTH)
//   RESET_PC  fetch PC after reset
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high
//   flush           taken branch: empty the queue, redirect fetch
//   flushTarget     branch target address
//   hold            IF/ID stall: head entry must not be consumed
//   memAddr         instruction memory read address (the fetch PC)
//   memData         instruction word at memAddr, same cycle
//   instructionOut  head instruction, zero when not valid
//   PCPlus4Out      head PC+4, zero when not valid
//   validOut        head entry present
//   count           occupied entries, 0..DEPTH

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [31:0]      flushTarget,
  input  logic             hold,
  output logic [31:0]      memAddr,
  input  logic [31:0]      memData,
  output logic [31:0]      instructionOut,
  output logic [31:0]      PCPlus4Out,
  output logic             validOut,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_plus4;
  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc4_mem   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   occ;

  logic empty;
  logic full;
  logic pop;       // head consumed by IF/ID this cycle
  logic q_pop;     // pop that removes a stored entry
  logic push;      // memData written into the queue this cycle
  logic advance;   // fetch PC moves to the next word

  assign fetch_pc_plus4 = fetch_pc + 32'd4;
  assign memAddr        = fetch_pc;
  assign count          = occ;
  assign empty          = (occ == '0);
  assign full           = (occ == FULL_COUNT);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_active;
  logic bypass_pop;

  // While empty, the word currently on memData stands in for the head.
  assign bypass_active = empty & ~reset & ~flush;

  always_comb begin
    instructionOut = 32'h00000000;
    PCPlus4Out     = 32'h00000000;
    validOut       = 1'b0;
    if (!empty) begin
      instructionOut = instr_mem[rd_ptr];
      PCPlus4Out     = pc4_mem[rd_ptr];
      validOut       = 1'b1;
    end else if (bypass_active) begin
      instructionOut = memData;
      PCPlus4Out     = fetch_pc_plus4;
      validOut       = 1'b1;
    end
  end

  assign pop        = validOut & ~hold & ~flush;
  assign q_pop      = pop & ~empty;
  // A bypassed word that is consumed immediately never needs a slot.
  assign bypass_pop = pop & empty;
  assign push       = ~flush & (~full | pop) & ~bypass_pop;
  assign advance    = push | bypass_pop;
`else
  always_comb begin
    instructionOut = 32'h00000000;
    PCPlus4Out     = 32'h00000000;
    validOut       = 1'b0;
    if (!empty) begin
      instructionOut = instr_mem[rd_ptr];
      PCPlus4Out     = pc4_mem[rd_ptr];
      validOut       = 1'b1;
    end
  end

  assign pop     = validOut & ~hold & ~flush;
  assign q_pop   = pop;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign push    = ~flush & (~full | pop);
  assign advance = push;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
    end else if (flush) begin
      // The word fetched in the flush cycle is from the wrong path; drop it.
      fetch_pc <= flushTarget;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
    end else begin
      if (advance) begin
        fetch_pc <= fetch_pc_plus4;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (q_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, q_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage has no reset; entries are only observed when occ covers them.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem[wr_ptr] <= memData;
      pc4_mem[wr_ptr]   <= fetch_pc_plus4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue

module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flushTarget;
  logic        hold;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic [31:0] instructionOut;
  logic [31:0] PCPlus4Out;
  logic        validOut;
  logic [2:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instruction memory: word[i] = 32'h20080000 + i at address 4i.
  assign memData = 32'h20080000 + {2'b00, memAddr[31:2]};

  fetch_queue #(
    .DEPTH(4),
    .PTR_W(2),
    .RESET_PC(32'h00000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .flushTarget(flushTarget),
    .hold(hold),
    .memAddr(memAddr),
    .memData(memData),
    .instructionOut(instructionOut),
    .PCPlus4Out(PCPlus4Out),
    .validOut(validOut),
    .count(count)
  );

  function automatic logic [31:0] word(input int i);
    word = 32'h20080000 + i;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; hold = 1'b0; flushTarget = 32'h0;
    step(); step();
    vectors++; if (validOut !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", validOut); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (instructionOut !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", instructionOut); end
    vectors++; if (PCPlus4Out !== 32'h0) begin miscompares++; $display("FAIL reset_pc4 got %h want 0", PCPlus4Out); end
    vectors++; if (memAddr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", memAddr); end
  endtask

  task automatic test_stream();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (instructionOut !== word(i)) begin miscompares++; $display("FAIL stream_instr[%0d] got %h want %h", i, instructionOut, word(i)); end
      vectors++; if (PCPlus4Out !== 32'(4 * (i + 1))) begin miscompares++; $display("FAIL stream_pc4[%0d] got %h want %h", i, PCPlus4Out, 4 * (i + 1)); end
      vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL stream_count[%0d] got %0d want 1", i, count); end
      vectors++; if (validOut !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %b want 1", i, validOut); end
    end
  endtask

  task automatic test_hold();
    logic [2:0]  exp_count;
    logic [31:0] exp_addr;
    hold = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_count = (k >= 3) ? 3'd4 : 3'(1 + k);
      exp_addr  = (k >= 3) ? 32'd24 : 32'(12 + 4 * k);
      vectors++; if (count !== exp_count) begin miscompares++; $display("FAIL hold_count[%0d] got %0d want %0d", k, count, exp_count); end
      vectors++; if (memAddr !== exp_addr) begin miscompares++; $display("FAIL hold_addr[%0d] got %h want %h", k, memAddr, exp_addr); end
      vectors++; if (instructionOut !== word(2)) begin miscompares++; $display("FAIL hold_head[%0d] got %h want %h", k, instructionOut, word(2)); end
    end
  endtask

  task automatic test_full_release();
    hold = 1'b0;
    #1;
    vectors++; if (instructionOut !== word(2)) begin miscompares++; $display("FAIL release_head got %h want %h", instructionOut, word(2)); end
    for (int i = 3; i <= 6; i++) begin
      step();
      vectors++; if (instructionOut !== word(i)) begin miscompares++; $display("FAIL release_instr[%0d] got %h want %h", i, instructionOut, word(i)); end
      vectors++; if (PCPlus4Out !== 32'(4 * (i + 1))) begin miscompares++; $display("FAIL release_pc4[%0d] got %h want %h", i, PCPlus4Out, 4 * (i + 1)); end
      vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL release_count[%0d] got %0d want 4", i, count); end
      vectors++; if (memAddr !== 32'(4 * (i + 4))) begin miscompares++; $display("FAIL release_addr[%0d] got %h want %h", i, memAddr, 4 * (i + 4)); end
    end
  endtask

  task automatic test_reset_midstream();
    hold = 1'b1; reset = 1'b1;
    step();
    vectors++; if (validOut !== 1'b0) begin miscompares++; $display("FAIL midreset_valid got %b want 0", validOut); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL midreset_count got %0d want 0", count); end
    vectors++; if (memAddr !== 32'h0) begin miscompares++; $display("FAIL midreset_addr got %h want 0", memAddr); end
    vectors++; if (instructionOut !== 32'h0) begin miscompares++; $display("FAIL midreset_instr got %h want 0", instructionOut); end
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      vectors++; if (count !== 3'(k)) begin miscompares++; $display("FAIL refill_count[%0d] got %0d want %0d", k, count, k); end
      vectors++; if (instructionOut !== word(0)) begin miscompares++; $display("FAIL refill_head[%0d] got %h want %h", k, instructionOut, word(0)); end
      vectors++; if (memAddr !== 32'(4 * k)) begin miscompares++; $display("FAIL refill_addr[%0d] got %h want %h", k, memAddr, 4 * k); end
    end
  endtask

  task automatic test_flush_hold();
    flush = 1'b1; flushTarget = 32'h00000040; hold = 1'b1;
    step();
    vectors++; if (validOut !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", validOut); end
    vectors++; if (instructionOut !== 32'h0) begin miscompares++; $display("FAIL flush_instr got %h want 0", instructionOut); end
    vectors++; if (PCPlus4Out !== 32'h0) begin miscompares++; $display("FAIL flush_pc4 got %h want 0", PCPlus4Out); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL flush_count got %0d want 0", count); end
    vectors++; if (memAddr !== 32'h40) begin miscompares++; $display("FAIL flush_addr got %h want 40", memAddr); end
    flush = 1'b0; hold = 1'b0;
    step();
    vectors++; if (validOut !== 1'b1) begin miscompares++; $display("FAIL target_valid got %b want 1", validOut); end
    vectors++; if (instructionOut !== word(16)) begin miscompares++; $display("FAIL target_instr got %h want %h", instructionOut, word(16)); end
    vectors++; if (PCPlus4Out !== 32'h44) begin miscompares++; $display("FAIL target_pc4 got %h want 44", PCPlus4Out); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL target_count got %0d want 1", count); end
  endtask

  task automatic test_pc_wrap();
    flush = 1'b1; flushTarget = 32'hFFFFFFFC;
    step();
    vectors++; if (memAddr !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL wrap_addr0 got %h want fffffffc", memAddr); end
    flush = 1'b0;
    step();
    vectors++; if (instructionOut !== 32'h6007FFFF) begin miscompares++; $display("FAIL wrap_instr got %h want 6007ffff", instructionOut); end
    vectors++; if (PCPlus4Out !== 32'h0) begin miscompares++; $display("FAIL wrap_pc4 got %h want 0", PCPlus4Out); end
    vectors++; if (memAddr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr1 got %h want 0", memAddr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_full_release();
    test_reset_midstream();
    test_flush_hold();
    test_pc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
